axi_mem_slave: RTL and testbench

AXI4 memory responder: the subordinate end of the CPU's AXI4 master port. It accepts read and write bursts on the five AXI channels and services them from an internal word-addressed RAM. It sits behind the top-level memory AXI interface in standalone and bench builds, in place of the external simulation memory.

---
 rtl/axi_mem_slave.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// axi_mem_slave
// -----------------------------------------------------------------------------
// AXI4 memory responder. Services read and write bursts from the CPU's AXI4
// master port out of an internal word-addressed RAM (one beat == one word).
// Read and write paths are independent FSMs, each with one transaction in
// flight. prot/lock/cache/qos, awlen and the size fields are accepted but
// ignored. Every beat moves a full word; byte lanes are selected by wstrb.
//
// Ports
//   clock, reset         : single clock, synchronous active-low reset
//   axi_aw_* / axi_w_*   : write address / write data channels (inputs + ready)
//   axi_b_*              : write response channel
//   axi_ar_*             : read address channel
//   axi_r_*              : read data channel
//   dbg_r_state_o        : read FSM state (R_IDLE=0, R_WAIT=1, R_DATA=2)
//   dbg_w_state_o        : write FSM state (W_IDLE=0, W_DATA=1, W_RESP=2)
//
// Build option
//   AXI_MEM_SLAVE_ERR_EN : when defined, bursts starting outside
//                          [BASE_ADDR, BASE_ADDR + MEM_WORDS*DATA_WIDTH/8)
//                          answer SLVERR, return zero read data and drop
//                          their writes. When undefined, resp is always OKAY
//                          and addresses alias modulo the memory size.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it, and the payload next to it, stays constant
// until that edge; ready never depends combinationally on valid.
// -----------------------------------------------------------------------------
module axi_mem_slave #(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    ID_WIDTH     = 4,
  parameter int                    USER_WIDTH   = 1,
  parameter int                    MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 64'h8000_0000,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  // write address
  output logic                    axi_aw_ready_o,
  input  logic                    axi_aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [2:0]              axi_aw_prot_i,
  input  logic [ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [USER_WIDTH-1:0]   axi_aw_user_i,
  input  logic [7:0]              axi_aw_len_i,
  input  logic [2:0]              axi_aw_size_i,
  input  logic [1:0]              axi_aw_burst_i,
  input  logic                    axi_aw_lock_i,
  input  logic [3:0]              axi_aw_cache_i,
  input  logic [3:0]              axi_aw_qos_i,
  // write data
  output logic                    axi_w_ready_o,
  input  logic                    axi_w_valid_i,
  input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                    axi_w_last_i,
  // write response
  input  logic                    axi_b_ready_i,
  output logic                    axi_b_valid_o,
  output logic [1:0]              axi_b_resp_o,
  output logic [ID_WIDTH-1:0]     axi_b_id_o,
  output logic [USER_WIDTH-1:0]   axi_b_user_o,
  // read address
  output logic                    axi_ar_ready_o,
  input  logic                    axi_ar_valid_i,
  input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [2:0]              axi_ar_prot_i,
  input  logic [ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [USER_WIDTH-1:0]   axi_ar_user_i,
  input  logic [7:0]              axi_ar_len_i,
  input  logic [2:0]              axi_ar_size_i,
  input  logic [1:0]              axi_ar_burst_i,
  input  logic                    axi_ar_lock_i,
  input  logic [3:0]              axi_ar_cache_i,
  input  logic [3:0]              axi_ar_qos_i,
  // read data
  input  logic                    axi_r_ready_i,
  output logic                    axi_r_valid_o,
  output logic [1:0]              axi_r_resp_o,
  output logic [DATA_WIDTH-1:0]   axi_r_data_o,
  output logic                    axi_r_last_o,
  output logic [ID_WIDTH-1:0]     axi_r_id_o,
  output logic [USER_WIDTH-1:0]   axi_r_user_o,
  // debug
  output logic [1:0]              dbg_r_state_o,
  output logic [1:0]              dbg_w_state_o
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(MEM_WORDS);

  localparam logic [3:0]       LAT     = 4'(READ_LATENCY);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode: byte offset from BASE_ADDR, then word index. Subtraction
  // wraps, so with the range check disabled low addresses alias naturally.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] ar_off, aw_off;
  logic [IDX_W-1:0]      ar_idx, aw_idx;
  logic                  ar_err, aw_err;

  assign ar_off = axi_ar_addr_i - BASE_ADDR;
  assign aw_off = axi_aw_addr_i - BASE_ADDR;
  assign ar_idx = ar_off[OFF_BITS +: IDX_W];
  assign aw_idx = aw_off[OFF_BITS +: IDX_W];

`ifdef AXI_MEM_SLAVE_ERR_EN
  localparam logic [ADDR_WIDTH-1:0] MEM_END = BASE_ADDR + ADDR_WIDTH'(MEM_WORDS * STRB_W);
  assign ar_err = (axi_ar_addr_i < BASE_ADDR) || (axi_ar_addr_i >= MEM_END);
  assign aw_err = (axi_aw_addr_i < BASE_ADDR) || (axi_aw_addr_i >= MEM_END);
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{axi_aw_prot_i, axi_aw_len_i, axi_aw_size_i, axi_aw_lock_i,
                           axi_aw_cache_i, axi_aw_qos_i, axi_ar_prot_i, axi_ar_size_i,
                           axi_ar_lock_i, axi_ar_cache_i, axi_ar_qos_i, ar_off, aw_off};

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [1:0]            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [USER_WIDTH-1:0] r_user_q, r_user_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [1:0]            r_burst_q, r_burst_d;
  logic [7:0]            r_beat_q, r_beat_d;
  logic [3:0]            r_lat_q, r_lat_d;
  logic                  r_err_q, r_err_d;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_user_d  = r_user_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_lat_d   = r_lat_q;
    r_err_d   = r_err_q;
    case (r_state_q)
      R_IDLE: begin
        if (axi_ar_valid_i) begin
          r_id_d    = axi_ar_id_i;
          r_user_d  = axi_ar_user_i;
          r_idx_d   = ar_idx;
          r_len_d   = axi_ar_len_i;
          r_burst_d = axi_ar_burst_i;
          r_beat_d  = 8'd0;
          r_lat_d   = LAT;
          r_err_d   = ar_err;
          r_state_d = (LAT == 4'd0) ? R_DATA : R_WAIT;
        end
      end
      R_WAIT: begin
        // Leaving on the cycle the counter hits zero gives exactly LAT idle
        // cycles between AR acceptance and the first R beat.
        r_lat_d = r_lat_q - 4'd1;
        if (r_lat_q <= 4'd1) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi_r_ready_i) begin
          r_beat_d = r_beat_q + 8'd1;
          r_idx_d  = (r_burst_q == BURST_FIXED) ? r_idx_q : r_idx_q + IDX_ONE;
          if (r_beat_q == r_len_q) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [1:0]            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [USER_WIDTH-1:0] w_user_q, w_user_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [1:0]            w_burst_q, w_burst_d;
  logic                  w_err_q, w_err_d;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_user_d  = w_user_q;
    w_idx_d   = w_idx_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    case (w_state_q)
      W_IDLE: begin
        if (axi_aw_valid_i) begin
          w_id_d    = axi_aw_id_i;
          w_user_d  = axi_aw_user_i;
          w_idx_d   = aw_idx;
          w_burst_d = axi_aw_burst_i;
          w_err_d   = aw_err;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_w_valid_i) begin
          w_idx_d = (w_burst_q == BURST_FIXED) ? w_idx_q : w_idx_q + IDX_ONE;
          // wlast alone terminates the burst; awlen is not tracked.
          if (axi_w_last_i) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_user_q  <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_lat_q   <= '0;
      r_err_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_user_q  <= '0;
      w_idx_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_user_q  <= r_user_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_lat_q   <= r_lat_d;
      r_err_q   <= r_err_d;
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_user_q  <= w_user_d;
      w_idx_q   <= w_idx_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM: byte-masked write, combinational read. A read of the word being
  // written in the same cycle sees the old contents; the RAM is not reset.
  // ---------------------------------------------------------------------------
  logic w_fire;
  assign w_fire = axi_w_valid_i && axi_w_ready_o && !w_err_q;

  always_ff @(posedge clock) begin
    if (w_fire) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (axi_w_strb_i[i]) mem_q[w_idx_q][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Qualifying with reset keeps every channel quiet for the whole
  // time reset is low, including the first cycle before the state registers
  // have been cleared.
  // ---------------------------------------------------------------------------
  logic r_active, b_active;
  assign r_active = reset && (r_state_q == R_DATA);
  assign b_active = reset && (w_state_q == W_RESP);

  assign axi_ar_ready_o = reset && (r_state_q == R_IDLE);
  assign axi_r_valid_o  = r_active;
  assign axi_r_data_o   = (r_active && !r_err_q) ? mem_q[r_idx_q] : '0;
  assign axi_r_last_o   = r_active && (r_beat_q == r_len_q);
  assign axi_r_resp_o   = (r_active && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_r_id_o     = r_active ? r_id_q : '0;
  assign axi_r_user_o   = r_active ? r_user_q : '0;

  assign axi_aw_ready_o = reset && (w_state_q == W_IDLE);
  assign axi_w_ready_o  = reset && (w_state_q == W_DATA);
  assign axi_b_valid_o  = b_active;
  assign axi_b_resp_o   = (b_active && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign axi_b_id_o     = b_active ? w_id_q : '0;
  assign axi_b_user_o   = b_active ? w_user_q : '0;

  assign dbg_r_state_o = r_state_q;
  assign dbg_w_state_o = w_state_q;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: preloads the RAM over AXI, then walks
// through single/INCR/FIXED/WRAP reads, a strobed write, a same-word
// read/write collision, the out-of-range case and a reset mid-burst.
module tb_axi_mem_slave;

  localparam int          LAT  = 2;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0]  INCR = 2'b01;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        axi_aw_ready_o, axi_aw_valid_i;
  logic [63:0] axi_aw_addr_i;
  logic [2:0]  axi_aw_prot_i;
  logic [3:0]  axi_aw_id_i;
  logic [0:0]  axi_aw_user_i;
  logic [7:0]  axi_aw_len_i;
  logic [2:0]  axi_aw_size_i;
  logic [1:0]  axi_aw_burst_i;
  logic        axi_aw_lock_i;
  logic [3:0]  axi_aw_cache_i, axi_aw_qos_i;
  logic        axi_w_ready_o, axi_w_valid_i;
  logic [63:0] axi_w_data_i;
  logic [7:0]  axi_w_strb_i;
  logic        axi_w_last_i;
  logic        axi_b_ready_i, axi_b_valid_o;
  logic [1:0]  axi_b_resp_o;
  logic [3:0]  axi_b_id_o;
  logic [0:0]  axi_b_user_o;
  logic        axi_ar_ready_o, axi_ar_valid_i;
  logic [63:0] axi_ar_addr_i;
  logic [2:0]  axi_ar_prot_i;
  logic [3:0]  axi_ar_id_i;
  logic [0:0]  axi_ar_user_i;
  logic [7:0]  axi_ar_len_i;
  logic [2:0]  axi_ar_size_i;
  logic [1:0]  axi_ar_burst_i;
  logic        axi_ar_lock_i;
  logic [3:0]  axi_ar_cache_i, axi_ar_qos_i;
  logic        axi_r_ready_i, axi_r_valid_o;
  logic [1:0]  axi_r_resp_o;
  logic [63:0] axi_r_data_o;
  logic        axi_r_last_o;
  logic [3:0]  axi_r_id_o;
  logic [0:0]  axi_r_user_o;
  logic [1:0]  dbg_r_state_o, dbg_w_state_o;

  axi_mem_slave #(.READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .axi_aw_ready_o(axi_aw_ready_o), .axi_aw_valid_i(axi_aw_valid_i),
    .axi_aw_addr_i(axi_aw_addr_i), .axi_aw_prot_i(axi_aw_prot_i),
    .axi_aw_id_i(axi_aw_id_i), .axi_aw_user_i(axi_aw_user_i),
    .axi_aw_len_i(axi_aw_len_i), .axi_aw_size_i(axi_aw_size_i),
    .axi_aw_burst_i(axi_aw_burst_i), .axi_aw_lock_i(axi_aw_lock_i),
    .axi_aw_cache_i(axi_aw_cache_i), .axi_aw_qos_i(axi_aw_qos_i),
    .axi_w_ready_o(axi_w_ready_o), .axi_w_valid_i(axi_w_valid_i),
    .axi_w_data_i(axi_w_data_i), .axi_w_strb_i(axi_w_strb_i), .axi_w_last_i(axi_w_last_i),
    .axi_b_ready_i(axi_b_ready_i), .axi_b_valid_o(axi_b_valid_o),
    .axi_b_resp_o(axi_b_resp_o), .axi_b_id_o(axi_b_id_o), .axi_b_user_o(axi_b_user_o),
    .axi_ar_ready_o(axi_ar_ready_o), .axi_ar_valid_i(axi_ar_valid_i),
    .axi_ar_addr_i(axi_ar_addr_i), .axi_ar_prot_i(axi_ar_prot_i),
    .axi_ar_id_i(axi_ar_id_i), .axi_ar_user_i(axi_ar_user_i),
    .axi_ar_len_i(axi_ar_len_i), .axi_ar_size_i(axi_ar_size_i),
    .axi_ar_burst_i(axi_ar_burst_i), .axi_ar_lock_i(axi_ar_lock_i),
    .axi_ar_cache_i(axi_ar_cache_i), .axi_ar_qos_i(axi_ar_qos_i),
    .axi_r_ready_i(axi_r_ready_i), .axi_r_valid_o(axi_r_valid_o),
    .axi_r_resp_o(axi_r_resp_o), .axi_r_data_o(axi_r_data_o), .axi_r_last_o(axi_r_last_o),
    .axi_r_id_o(axi_r_id_o), .axi_r_user_o(axi_r_user_o),
    .dbg_r_state_o(dbg_r_state_o), .dbg_w_state_o(dbg_w_state_o)
  );

  // ---------------------------------------------------------------- scoreboard
  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wdata [8];
  int          n_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_sel(input int s);
    case (s)
      0:       return axi_ar_ready_o;
      1:       return axi_aw_ready_o;
      2:       return axi_w_ready_o;
      3:       return axi_r_valid_o;
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait, sampled on falling edges; n = falling edges seen.
  task automatic wait_sig(input int s, input string tag, output int n);
    n = 1;
    @(negedge clock);
    while (!sig_sel(s) && n < 64) begin
      @(negedge clock);
      n++;
    end
    chk(tag, 64'(sig_sel(s)), 64'd1);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic do_write(input logic [63:0] addr, input int nb, input logic [1:0] burst,
                          input logic [7:0] strb, input logic [3:0] id, input logic [1:0] exp_resp);
    int n;
    @(posedge clock); #1;
    axi_aw_valid_i = 1'b1; axi_aw_addr_i = addr; axi_aw_burst_i = burst;
    axi_aw_id_i = id; axi_aw_len_i = 8'(nb - 1);
    wait_sig(1, "aw_ready", n);
    @(posedge clock); #1 axi_aw_valid_i = 1'b0;
    for (int k = 0; k < nb; k++) begin
      axi_w_valid_i = 1'b1; axi_w_data_i = wdata[k]; axi_w_strb_i = strb;
      axi_w_last_i = (k == nb - 1);
      wait_sig(2, "w_ready", n);
      @(posedge clock); #1;
    end
    axi_w_valid_i = 1'b0; axi_w_last_i = 1'b0;
    @(negedge clock);
    chk("b_valid_t1", 64'(axi_b_valid_o), 64'd1);
    chk("b_resp", 64'(axi_b_resp_o), 64'(exp_resp));
    chk("b_id", 64'(axi_b_id_o), 64'(id));
    axi_b_ready_i = 1'b1;
    @(posedge clock); #1 axi_b_ready_i = 1'b0;
    @(negedge clock);
    chk("aw_ready_after_b", 64'(axi_aw_ready_o), 64'd1);
    chk("b_valid_after_b", 64'(axi_b_valid_o), 64'd0);
  endtask

  // Expected beat data must already be in exp_q.
  task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [3:0] id, input bit toggle, input logic [1:0] exp_resp,
                         input bit chk_lat);
    int n;
    int beats;
    int cyc;
    @(posedge clock); #1;
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = addr; axi_ar_len_i = len;
    axi_ar_burst_i = burst; axi_ar_id_i = id; axi_ar_user_i = id[0]; axi_r_ready_i = 1'b1;
    wait_sig(0, "ar_ready", n);
    @(posedge clock); #1 axi_ar_valid_i = 1'b0;
    wait_sig(3, "r_valid_first", n);
    if (chk_lat) chk("r_latency", 64'(n), 64'(LAT + 1));
    beats = 0;
    cyc   = 0;
    while (beats <= int'(len) && cyc < 64) begin
      chk("r_valid_hold", 64'(axi_r_valid_o), 64'd1);
      chk("r_data", axi_r_data_o, (exp_q.size() > 0) ? exp_q[0] : 64'hBAD0_BAD0_BAD0_BAD0);
      chk("r_last", 64'(axi_r_last_o), 64'(beats == int'(len)));
      chk("r_id", 64'(axi_r_id_o), 64'(id));
      chk("r_user", 64'(axi_r_user_o), 64'(id[0]));
      chk("r_resp", 64'(axi_r_resp_o), 64'(exp_resp));
      if (axi_r_valid_o && axi_r_ready_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats++;
      end
      @(posedge clock); #1;
      if (toggle) axi_r_ready_i = ~axi_r_ready_i;
      @(negedge clock);
      cyc++;
    end
    axi_r_ready_i = 1'b0;
    chk("ar_ready_after_r", 64'(axi_ar_ready_o), 64'd1);
    chk("r_valid_after_r", 64'(axi_r_valid_o), 64'd0);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    axi_aw_valid_i = 0; axi_aw_addr_i = 0; axi_aw_prot_i = 0; axi_aw_id_i = 0;
    axi_aw_user_i = 0; axi_aw_len_i = 0; axi_aw_size_i = 3'd3; axi_aw_burst_i = INCR;
    axi_aw_lock_i = 0; axi_aw_cache_i = 0; axi_aw_qos_i = 0;
    axi_w_valid_i = 0; axi_w_data_i = 0; axi_w_strb_i = 0; axi_w_last_i = 0;
    axi_b_ready_i = 0;
    axi_ar_valid_i = 0; axi_ar_addr_i = 0; axi_ar_prot_i = 0; axi_ar_id_i = 0;
    axi_ar_user_i = 0; axi_ar_len_i = 0; axi_ar_size_i = 3'd3; axi_ar_burst_i = INCR;
    axi_ar_lock_i = 0; axi_ar_cache_i = 0; axi_ar_qos_i = 0;
    axi_r_ready_i = 0;

    // Reset state: everything quiet while reset is low.
    @(negedge clock);
    chk("rst_ar_ready", 64'(axi_ar_ready_o), 64'd0);
    chk("rst_aw_ready", 64'(axi_aw_ready_o), 64'd0);
    chk("rst_w_ready", 64'(axi_w_ready_o), 64'd0);
    chk("rst_r_valid", 64'(axi_r_valid_o), 64'd0);
    chk("rst_b_valid", 64'(axi_b_valid_o), 64'd0);
    chk("rst_r_data", axi_r_data_o, 64'd0);
    chk("rst_r_last", 64'(axi_r_last_o), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("post_rst_ar_ready", 64'(axi_ar_ready_o), 64'd1);
    chk("post_rst_aw_ready", 64'(axi_aw_ready_o), 64'd1);
    chk("post_rst_r_state", 64'(dbg_r_state_o), 64'd0);

    // Preload over AXI.
    wdata[0] = 64'h1122_3344_5566_7788;
    do_write(BASE, 1, INCR, 8'hFF, 4'd5, 2'b00);
    wdata[0] = 64'h1111_1111_1111_1111; wdata[1] = 64'h2222_2222_2222_2222;
    wdata[2] = 64'h3333_3333_3333_3333; wdata[3] = 64'h4444_4444_4444_4444;
    wdata[4] = 64'h5555_5555_5555_5555;
    do_write(BASE + 64'h8, 5, INCR, 8'hFF, 4'd6, 2'b00);
    wdata[0] = 64'hDEAD_BEEF_0000_0200;
    do_write(BASE + 64'h1000, 1, INCR, 8'hFF, 4'd7, 2'b00);
    wdata[0] = 64'h6666_6666_6666_6666;
    do_write(BASE + 64'h30, 1, INCR, 8'hFF, 4'd8, 2'b00);

    // Single read, latency checked.
    exp_q.push_back(64'h1122_3344_5566_7788);
    do_read(BASE, 8'd0, INCR, 4'd3, 1'b0, 2'b00, 1'b1);

    // INCR 4 beats from word 2 with r_ready toggling.
    exp_q.push_back(64'h2222_2222_2222_2222); exp_q.push_back(64'h3333_3333_3333_3333);
    exp_q.push_back(64'h4444_4444_4444_4444); exp_q.push_back(64'h5555_5555_5555_5555);
    do_read(BASE + 64'h10, 8'd3, INCR, 4'd9, 1'b1, 2'b00, 1'b1);

    // Strobed write into word 1, lower four bytes only.
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(BASE + 64'h8, 1, INCR, 8'h0F, 4'd2, 2'b00);
    exp_q.push_back(64'h1111_1111_FFFF_FFFF);
    do_read(BASE + 64'h8, 8'd0, INCR, 4'd2, 1'b0, 2'b00, 1'b0);

    // FIXED burst repeats the same word; WRAP behaves as INCR.
    exp_q.push_back(64'h2222_2222_2222_2222); exp_q.push_back(64'h2222_2222_2222_2222);
    do_read(BASE + 64'h10, 8'd1, 2'b00, 4'd4, 1'b0, 2'b00, 1'b0);
    exp_q.push_back(64'h2222_2222_2222_2222); exp_q.push_back(64'h3333_3333_3333_3333);
    do_read(BASE + 64'h10, 8'd1, 2'b10, 4'd11, 1'b0, 2'b00, 1'b0);

    // Same-word read and write in one cycle: R sees the old word.
    @(posedge clock); #1;
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = BASE + 64'h30; axi_ar_len_i = 8'd0;
    axi_ar_burst_i = INCR; axi_ar_id_i = 4'd1; axi_ar_user_i = 1'b1; axi_r_ready_i = 1'b0;
    wait_sig(0, "rw_ar_ready", n_w);
    @(posedge clock); #1 axi_ar_valid_i = 1'b0;
    axi_aw_valid_i = 1'b1; axi_aw_addr_i = BASE + 64'h30; axi_aw_id_i = 4'd2;
    axi_aw_len_i = 8'd0; axi_aw_burst_i = INCR;
    wait_sig(1, "rw_aw_ready", n_w);
    @(posedge clock); #1 axi_aw_valid_i = 1'b0;
    wait_sig(3, "rw_r_valid", n_w);
    @(posedge clock); #1;
    axi_r_ready_i = 1'b1; axi_w_valid_i = 1'b1; axi_w_data_i = 64'h7777_7777_7777_7777;
    axi_w_strb_i = 8'hFF; axi_w_last_i = 1'b1;
    @(negedge clock);
    chk("rw_r_valid_held", 64'(axi_r_valid_o), 64'd1);
    chk("rw_w_ready", 64'(axi_w_ready_o), 64'd1);
    chk("rw_same_old", axi_r_data_o, 64'h6666_6666_6666_6666);
    @(posedge clock); #1;
    axi_r_ready_i = 1'b0; axi_w_valid_i = 1'b0; axi_w_last_i = 1'b0;
    @(negedge clock);
    chk("rw_b_valid", 64'(axi_b_valid_o), 64'd1);
    chk("rw_r_done", 64'(axi_r_valid_o), 64'd0);
    axi_b_ready_i = 1'b1;
    @(posedge clock); #1 axi_b_ready_i = 1'b0;
    exp_q.push_back(64'h7777_7777_7777_7777);
    do_read(BASE + 64'h30, 8'd0, INCR, 4'd1, 1'b0, 2'b00, 1'b0);

    // Out-of-range read below BASE.
`ifdef AXI_MEM_SLAVE_ERR_EN
    exp_q.push_back(64'd0);
    do_read(64'h1000, 8'd0, INCR, 4'd7, 1'b0, 2'b10, 1'b0);
`else
    exp_q.push_back(64'hDEAD_BEEF_0000_0200);
    do_read(64'h1000, 8'd0, INCR, 4'd7, 1'b0, 2'b00, 1'b0);
`endif

    // Reset during the 2nd beat of a 4-beat read.
    @(posedge clock); #1;
    axi_ar_valid_i = 1'b1; axi_ar_addr_i = BASE; axi_ar_len_i = 8'd3;
    axi_ar_burst_i = INCR; axi_ar_id_i = 4'd0; axi_ar_user_i = 1'b0; axi_r_ready_i = 1'b1;
    wait_sig(0, "mid_ar_ready", n_w);
    @(posedge clock); #1 axi_ar_valid_i = 1'b0;
    wait_sig(3, "mid_r_valid", n_w);
    chk("mid_beat0", axi_r_data_o, 64'h1122_3344_5566_7788);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_r_valid", 64'(axi_r_valid_o), 64'd0);
    chk("mid_rst_ar_ready", 64'(axi_ar_ready_o), 64'd0);
    chk("mid_rst_r_data", axi_r_data_o, 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_rst_r_valid_next", 64'(axi_r_valid_o), 64'd0);
    chk("mid_rst_r_last", 64'(axi_r_last_o), 64'd0);
    @(posedge clock); #1 reset = 1'b1; axi_r_ready_i = 1'b0;
    @(negedge clock);
    chk("mid_rel_ar_ready", 64'(axi_ar_ready_o), 64'd1);
    chk("mid_rel_aw_ready", 64'(axi_aw_ready_o), 64'd1);
    chk("mid_rel_r_valid", 64'(axi_r_valid_o), 64'd0);
    chk("mid_rel_b_valid", 64'(axi_b_valid_o), 64'd0);

    // RAM contents survive reset.
    exp_q.push_back(64'h1122_3344_5566_7788);
    do_read(BASE, 8'd0, INCR, 4'd12, 1'b0, 2'b00, 1'b1);

    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
